// File: rtl/tinyml_cam_gray_binning.sv
// -----------------------------------------------------------------------------
// tinyml_cam_gray_binning
//
// 2x2 box-average downscale of a multi-pixel-per-clock grayscale stream.
// Even lines store horizontal pair sums in a line buffer. Odd lines add their
// own pair sums to the buffered ones and emit one averaged pixel per pair,
// registered, one cycle after the odd-line beat.
//
// Optional feature (compile-time macro TINYML_CAM_GRAY_BINNING_ROUND_EN):
//   defined   -> out pixel = (vsum + 2) >> 2  (round half up)
//   undefined -> out pixel =  vsum      >> 2  (truncate)
//
// Ports:
//   clk          pixel clock
//   rstn         synchronous active-low reset
//   in_valid     input beat qualifier
//   in_sof       first beat of frame (sampled with in_valid)
//   in_eol       last beat of line   (sampled with in_valid)
//   in_gray      PPC pixels, pixel 0 in the LSBs
//   out_valid    output beat qualifier
//   out_sof      first output beat of frame
//   out_eol      last output beat of line
//   out_gray     PPC/2 binned pixels, pixel 0 in the LSBs
//   out_overflow sticky: a line in the current frame exceeded MAX_WIDTH
// -----------------------------------------------------------------------------
module tinyml_cam_gray_binning #(
  parameter int DATA_WIDTH = 8,
  parameter int PPC        = 2,
  parameter int MAX_WIDTH  = 640
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             in_valid,
  input  logic                             in_sof,
  input  logic                             in_eol,
  input  logic [PPC*DATA_WIDTH-1:0]        in_gray,
  output logic                             out_valid,
  output logic                             out_sof,
  output logic                             out_eol,
  output logic [(PPC/2)*DATA_WIDTH-1:0]    out_gray,
  output logic                             out_overflow
);

  localparam int HP    = PPC / 2;               // output pixels per beat
  localparam int DEPTH = MAX_WIDTH / PPC;        // beats per maximum line
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);      // col must also hold DEPTH
  localparam int SW    = DATA_WIDTH + 1;         // one horizontal pair sum
  localparam int LW    = HP * SW;                // one line-buffer word

  // Column value meaning "line already full"; further beats are dropped.
  localparam logic [CW-1:0] COL_MAX = CW'(DEPTH);

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } parity_t;

  // Average of two pair sums (four pixels). The widened sum keeps the
  // rounding constant from wrapping, so the result always fits DATA_WIDTH.
  function automatic logic [DATA_WIDTH-1:0] bin_pixel(input logic [SW-1:0] a,
                                                      input logic [SW-1:0] b);
    logic [DATA_WIDTH+1:0] v;
    v = {1'b0, a} + {1'b0, b};
`ifdef TINYML_CAM_GRAY_BINNING_ROUND_EN
    v = v + (DATA_WIDTH + 2)'(2);
`endif
    return DATA_WIDTH'(v >> 2);
  endfunction

  parity_t                          parity_q, parity_d;
  logic [CW-1:0]                    col_q, col_d;
  logic                             sof_pending_q, sof_pending_d;
  logic                             overflow_q, overflow_d;
  logic                             out_valid_q, out_valid_d;
  logic                             out_sof_q, out_sof_d;
  logic                             out_eol_q, out_eol_d;
  logic [HP*DATA_WIDTH-1:0]         gray_q, gray_d;

  logic [LW-1:0]                    lbuf [DEPTH];
  logic [LW-1:0]                    hsum;
  logic [LW-1:0]                    rd_data;
  logic [AW-1:0]                    addr;
  logic                             wr_en;
  parity_t                          line_parity;
  logic [CW-1:0]                    line_col;

  // Horizontal pair sums of the incoming beat, kept at full width.
  always_comb begin
    hsum = '0;
    for (int k = 0; k < HP; k++) begin
      hsum[k*SW +: SW] = {1'b0, in_gray[(2*k)*DATA_WIDTH +: DATA_WIDTH]}
                       + {1'b0, in_gray[(2*k+1)*DATA_WIDTH +: DATA_WIDTH]};
    end
  end

  assign addr    = line_col[AW-1:0];
  assign rd_data = lbuf[addr];

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    parity_d      = parity_q;
    col_d         = col_q;
    sof_pending_d = sof_pending_q;
    overflow_d    = overflow_q;
    out_valid_d   = 1'b0;
    out_sof_d     = 1'b0;
    out_eol_d     = 1'b0;
    gray_d        = gray_q;
    wr_en         = 1'b0;
    line_parity   = parity_q;
    line_col      = col_q;

    if (in_valid) begin
      // A start-of-frame beat restarts the frame before being processed,
      // abandoning any half-binned odd line.
      if (in_sof) begin
        line_parity   = EVEN;
        line_col      = '0;
        sof_pending_d = 1'b1;
        overflow_d    = 1'b0;
      end

      if (line_col == COL_MAX) begin
        // Beyond the buffer: drop the beat. An eol still closes the line.
        if (in_eol) begin
          col_d    = '0;
          parity_d = (line_parity == EVEN) ? ODD : EVEN;
        end else begin
          col_d      = line_col;
          overflow_d = 1'b1;
        end
      end else begin
        col_d    = in_eol ? '0 : line_col + CW'(1);
        parity_d = in_eol ? ((line_parity == EVEN) ? ODD : EVEN) : line_parity;

        if (line_parity == EVEN) begin
          wr_en = 1'b1;
        end else begin
          out_valid_d   = 1'b1;
          out_sof_d     = sof_pending_q;
          out_eol_d     = in_eol;
          sof_pending_d = 1'b0;
          for (int k = 0; k < HP; k++) begin
            gray_d[k*DATA_WIDTH +: DATA_WIDTH] =
              bin_pixel(rd_data[k*SW +: SW], hsum[k*SW +: SW]);
          end
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      parity_q      <= EVEN;
      col_q         <= '0;
      sof_pending_q <= 1'b0;
      overflow_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_sof_q     <= 1'b0;
      out_eol_q     <= 1'b0;
      gray_q        <= '0;
    end else begin
      parity_q      <= parity_d;
      col_q         <= col_d;
      sof_pending_q <= sof_pending_d;
      overflow_q    <= overflow_d;
      out_valid_q   <= out_valid_d;
      out_sof_q     <= out_sof_d;
      out_eol_q     <= out_eol_d;
      gray_q        <= gray_d;
    end
  end

  // NOTE: the line buffer has no reset so it maps onto plain RAM; odd lines
  // only ever read entries that an even line has written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      lbuf[addr] <= hsum;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_sof      = out_sof_q;
  assign out_eol      = out_eol_q;
  assign out_gray     = gray_q;
  assign out_overflow = overflow_q;

endmodule

// File: doc/tinyml_cam_gray_binning.md
Name: tinyml_cam_gray_binning

Overview:
- Grayscale 2x2 binning (box-average downscale) stage directly downstream of the camera RGB-to-gray converter.
- Consumes the multi-pixel-per-clock gray stream.
- Emits a half-width, half-height gray stream for the tinyml input framebuffer writer.
- Uses one line buffer to hold horizontal pair sums of even lines; averages them with the odd lines.

Parameters:
- DATA_WIDTH, 8, bits per gray pixel.
- PPC, 2, input pixels per clock; must be even and >= 2; output carries PPC/2 pixels per beat.
- MAX_WIDTH, 640, maximum input line length in pixels; must be a multiple of PPC.

Ports:
- clk  in  1  pixel clock.
- rstn  in  1  synchronous active-low reset.
- in_valid  in  1  input beat qualifier.
- in_sof  in  1  first beat of frame; sampled only with in_valid.
- in_eol  in  1  last beat of line; sampled only with in_valid.
- in_gray  in  PPC*DATA_WIDTH  pixels; pixel 0 in the LSBs.
- out_valid  out  1  output beat qualifier.
- out_sof  out  1  first output beat of frame.
- out_eol  out  1  last output beat of line.
- out_gray  out  (PPC/2)*DATA_WIDTH  binned pixels; pixel 0 in the LSBs.
- out_overflow  out  1  sticky: a line exceeded MAX_WIDTH in the current frame.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous, active-low, on rstn.
- Reset values: all outputs 0, line parity = EVEN, column counter = 0, sof_pending = 0, out_overflow = 0. Line-buffer RAM contents are not reset.
- No backpressure. Input can arrive every cycle; idle gaps (in_valid=0) are allowed anywhere.
- Horizontal sum: for k in 0..PPC/2-1, hsum[k] = in_gray pixel 2k + pixel 2k+1, DATA_WIDTH+1 bits, no truncation.
- EVEN line: each valid beat writes the hsum vector to line buffer address col. No output is produced.
- ODD line: each valid beat reads address col.
  - vsum[k] = buffered hsum[k] + current hsum[k], DATA_WIDTH+2 bits.
  - out pixel k = vsum[k] >> 2 (see Optional Feature).
  - Line buffer: depth MAX_WIDTH/PPC, width (PPC/2)*(DATA_WIDTH+1). Read-before-write is not required; odd lines only read.
- Latency: the output beat is registered and appears exactly 1 cycle after the odd-line input beat. out_valid is high for exactly one cycle per odd-line input beat.
- Column counter col: increments on each valid beat. Cleared on a valid beat with in_eol.
- Line parity: toggles on each valid beat with in_eol.
- in_sof on a valid beat, even mid-line:
  - parity forced to EVEN; col forced to 0 before that beat is processed (the beat is written at address 0);
  - sof_pending set; out_overflow cleared.
  - Any partially binned odd line is abandoned. No terminating out_eol is generated.
- out_sof: asserted with the first output beat after sof_pending was set. sof_pending is cleared on that beat.
- out_eol: mirrors in_eol of the originating odd-line beat.
- Overflow: when col reaches MAX_WIDTH/PPC and a further valid non-eol beat arrives:
  - the beat is dropped (no write, no output);
  - col saturates; out_overflow set.
  - A subsequent in_eol beat that is itself beyond the limit is dropped, but still ends the line (col clear, parity toggle).
- Odd line longer than the preceding even line: reads return stale buffer data. This is legal and is not flagged.
- Odd number of lines in a frame: the final even line produces no output.
- Reset asserted mid-frame: all state cleared. The block waits for the next in_sof before emitting out_sof. Beats before the first in_sof are processed with parity EVEN from reset.

Optional Feature:
- Macro: TINYML_CAM_GRAY_BINNING_ROUND_EN.
- Defined: out pixel = (vsum + 2) >> 2 (round half up). vsum max 4*(2^DATA_WIDTH-1)+2 still fits in DATA_WIDTH+2 bits; the result never exceeds 2^DATA_WIDTH-1.
- Undefined: out pixel = vsum >> 2 (truncate). No extra adder is instantiated.

Test Plan:
- Basic bin: DATA_WIDTH=8, PPC=2, 4-pixel lines.
  - Stimulus: even line 10,20,30,40; odd line 30,40,50,60; in_sof on the first beat.
  - Required: outputs 25 then 45, each 1 cycle after its odd beat; out_sof on the first output, out_eol on the second.
- Rounding: pixels 0,0 / 0,1 (vsum=1) and 1,1 / 1,0 (vsum=3).
  - Required with ROUND_EN: outputs 0 and 1.
  - Required without ROUND_EN: outputs 0 and 0.
- Saturation values: all pixels 255.
  - Required: output 255 with both macro settings; no wrap to 0.
- Gaps: same stimulus as Basic bin with in_valid toggling 1,0,1,0.
  - Required: identical output values; out_valid occurs only 1 cycle after each valid odd beat.
- Overflow: MAX_WIDTH=8, a 12-pixel even line then a 12-pixel odd line.
  - Required: 4 outputs per odd line; out_overflow=1 from the 5th even beat; cleared by the next in_sof.
- Mid-line SOF: in_sof on the 2nd beat of an odd line.
  - Required: no output for that beat; parity EVEN; the next odd line's first output carries out_sof=1.
